// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode receiver: frame FSM states and
// the scancode values that are recognised as prefixes or modifier keys.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a registered
// falling-edge strobe on ps2 clock, with data delayed to stay aligned to it.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic fall_o,
   output logic data_o
);

   // clk_pipe: [0] metastability stage, [1] synchronized, [2] previous synchronized
   logic [2:0] clk_pipe_q,  clk_pipe_d;
   logic [1:0] data_pipe_q, data_pipe_d;
   logic       fall_q,      fall_d;
   logic       data_q,      data_d;

   always_comb begin
      clk_pipe_d  = {clk_pipe_q[1:0], ps2_clk_i};
      data_pipe_d = {data_pipe_q[0], ps2_data_i};
      fall_d      = clk_pipe_q[2] & ~clk_pipe_q[1];
      data_d      = data_pipe_q[1];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchronizer stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_pipe_q  <= 3'b111;
         data_pipe_q <= 2'b11;
         fall_q      <= 1'b0;
         data_q      <= 1'b1;
      end else begin
         clk_pipe_q  <= clk_pipe_d;
         data_pipe_q <= data_pipe_d;
         fall_q      <= fall_d;
         data_q      <= data_d;
      end
   end

   assign fall_o = fall_q;
   assign data_o = data_q;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into flags and
// strobes each scancode. Define PS2_MODIFIER_TRACK_EN to track shift/ctrl/alt.
module ps2_scancode_receiver #(
   parameter int TIMEOUT_CYCLES = 16384
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [7:0] code,
   output logic       codeValid,
   output logic       codeE0,
   output logic       codeRelease,
   output logic       frameError,
   output logic       shift,
   output logic       ctrl,
   output logic       alt,
   output logic       debugE0,
   output logic       debugF0
);

   import ps2_pkg::*;

   localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic ps2_fall;
   logic ps2_bit;

   ps2_sync_edge u_sync_edge (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk_i  (ps2Clk),
      .ps2_data_i (ps2Data),
      .fall_o     (ps2_fall),
      .data_o     (ps2_bit)
   );

   ps2_state_e       state_q,      state_d;
   logic [2:0]       bit_cnt_q,    bit_cnt_d;
   logic [7:0]       shreg_q,      shreg_d;
   logic             parity_ok_q,  parity_ok_d;
   logic [CNT_W-1:0] tmo_cnt_q,    tmo_cnt_d;
   logic [7:0]       code_q,       code_d;
   logic             code_valid_q, code_valid_d;
   logic             code_e0_q,    code_e0_d;
   logic             code_rel_q,   code_rel_d;
   logic             frame_err_q,  frame_err_d;
   logic             pend_e0_q,    pend_e0_d;
   logic             pend_f0_q,    pend_f0_d;
   logic             byte_done;
   logic             deliver;

   // NOTE: every signal written here gets a default first, so no path through
   // the case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      parity_ok_d  = parity_ok_q;
      tmo_cnt_d    = tmo_cnt_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      code_e0_d    = code_e0_q;
      code_rel_d   = code_rel_q;
      frame_err_d  = 1'b0;
      pend_e0_d    = pend_e0_q;
      pend_f0_d    = pend_f0_q;
      byte_done    = 1'b0;
      deliver      = 1'b0;

      // Silence watchdog: only a stalled partial frame can time out.
      if (ps2_fall || state_q == IDLE) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TIMEOUT_LAST) begin
         tmo_cnt_d   = '0;
         state_d     = IDLE;
         bit_cnt_d   = 3'd0;
         frame_err_d = 1'b1;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end

      if (ps2_fall) begin
         case (state_q)
            IDLE: begin
               if (!ps2_bit) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shreg_d   = {ps2_bit, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_ok_d = odd_parity_ok(shreg_q, ps2_bit);
               state_d     = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (ps2_bit && parity_ok_q) byte_done   = 1'b1;
               else                        frame_err_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end

      if (byte_done) begin
         if (shreg_q == SC_E0) begin
            pend_e0_d = 1'b1;
         end else if (shreg_q == SC_F0) begin
            pend_f0_d = 1'b1;
         end else begin
            deliver      = 1'b1;
            code_d       = shreg_q;
            code_valid_d = 1'b1;
            code_e0_d    = pend_e0_q;
            code_rel_d   = pend_f0_q;
            pend_e0_d    = 1'b0;
            pend_f0_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         shreg_q      <= 8'h00;
         parity_ok_q  <= 1'b0;
         tmo_cnt_q    <= '0;
         code_q       <= 8'h00;
         code_valid_q <= 1'b0;
         code_e0_q    <= 1'b0;
         code_rel_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         pend_e0_q    <= 1'b0;
         pend_f0_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         parity_ok_q  <= parity_ok_d;
         tmo_cnt_q    <= tmo_cnt_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         code_e0_q    <= code_e0_d;
         code_rel_q   <= code_rel_d;
         frame_err_q  <= frame_err_d;
         pend_e0_q    <= pend_e0_d;
         pend_f0_q    <= pend_f0_d;
      end
   end

   assign code        = code_q;
   assign codeValid   = code_valid_q;
   assign codeE0      = code_e0_q;
   assign codeRelease = code_rel_q;
   assign frameError  = frame_err_q;
   assign debugE0     = pend_e0_q;
   assign debugF0     = pend_f0_q;

`ifdef PS2_MODIFIER_TRACK_EN
   logic lshift_q, lshift_d;
   logic rshift_q, rshift_d;
   logic ctrl_q,   ctrl_d;
   logic alt_q,    alt_d;

   // E0-prefixed 0x12/0x59 are the fake shifts some keys emit, so shift ignores them.
   always_comb begin
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      ctrl_d   = ctrl_q;
      alt_d    = alt_q;
      if (deliver) begin
         case (shreg_q)
            SC_LSHIFT: if (!pend_e0_q) lshift_d = ~pend_f0_q;
            SC_RSHIFT: if (!pend_e0_q) rshift_d = ~pend_f0_q;
            SC_CTRL:   ctrl_d = ~pend_f0_q;
            SC_ALT:    alt_d  = ~pend_f0_q;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         ctrl_q   <= 1'b0;
         alt_q    <= 1'b0;
      end else begin
         lshift_q <= lshift_d;
         rshift_q <= rshift_d;
         ctrl_q   <= ctrl_d;
         alt_q    <= alt_d;
      end
   end

   assign shift = lshift_q | rshift_q;
   assign ctrl  = ctrl_q;
   assign alt   = alt_q;
`else
   assign shift = 1'b0;
   assign ctrl  = 1'b0;
   assign alt   = 1'b0;
`endif

endmodule
